decode_queue_stage: RTL

Parametrised decode stage with a DEPTH-entry decoded-instruction queue and an internal register scoreboard. It sits between fetch and the register-read/execute stage. Incoming words are decoded with the codebase `decode_inst` function and buffered. The oldest entry issues only when none of its registers has an outstanding write, and when issued its destination is reserved until writeback clears it. A branch flushes the queue in one cycle.

---
 rtl/decode_queue_stage.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/decode_queue_stage.sv
// Decode stage: decoded-instruction queue with a register scoreboard gating issue.

package decode_queue_stage_pkg;

  localparam int unsigned W_OP   = 8;
  localparam int unsigned D_INFO = 10;

  // Decoded control bits carried alongside each queued instruction
  typedef struct packed {
    logic       wrsv;      // destination r0 is written; reserve it on issue
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic [1:0] fmt;
    logic [3:0] alu_op;
  } d_info_t;

  // Opcode class in [7:6]: 00 alu, 01 load, 10 store, 11 branch
  function automatic d_info_t decode_inst(input logic [W_OP-1:0] opcode);
    d_info_t d;
    d           = '0;
    d.wrsv      = ~opcode[7];
    d.is_load   = (opcode[7:6] == 2'b01);
    d.is_store  = (opcode[7:6] == 2'b10);
    d.is_branch = (opcode[7:6] == 2'b11);
    d.fmt       = opcode[5:4];
    d.alu_op    = opcode[3:0];
    return d;
  endfunction

endpackage

module decode_queue_stage
  import decode_queue_stage_pkg::*;
#(
  parameter int unsigned WORD  = 32,
  parameter int unsigned ADDR  = 32,
  parameter int unsigned W_RD  = 4,
  parameter int unsigned W_IMM = WORD - 8 - 2*W_RD,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W_OPR = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       v_i,
  output logic                       stall_o,
  input  logic [WORD-1:0]            inst_i,
  input  logic [ADDR-1:0]            pc_i,
  input  logic                       branch_i,
  output logic                       v_o,
  input  logic                       stall_i,
  output logic [ADDR-1:0]            pc_o,
  output logic [W_IMM-1:0]           imm_o,
  output d_info_t                    d_info_o,
  output logic [W_RD-1:0]            r0_o,
  output logic [W_RD-1:0]            r1_o,
  input  logic [W_OPR-1:0]           r_opr0_i,
  input  logic [W_OPR-1:0]           r_opr1_i,
  output logic [W_OPR-1:0]           opr0_o,
  output logic [W_OPR-1:0]           opr1_o,
  output logic                       w_reserve_o,
  input  logic                       wb_v_i,
  input  logic [W_RD-1:0]            wb_r_i,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned NREG  = 2**W_RD;

  logic [ADDR-1:0]  pc_q   [DEPTH];
  logic [W_IMM-1:0] imm_q  [DEPTH];
  logic [W_RD-1:0]  r0_q   [DEPTH];
  logic [W_RD-1:0]  r1_q   [DEPTH];
  d_info_t          info_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [NREG-1:0]  busy_q, busy_d;

  logic [W_OP-1:0]  in_op;
  logic [W_RD-1:0]  in_r0, in_r1;
  logic [W_IMM-1:0] in_imm;
  logic             enq, issue, hazard;

  // Split the incoming word into its fields, MSB first
  assign in_op  = inst_i[WORD-1 -: W_OP];
  assign in_r0  = inst_i[WORD-W_OP-1 -: W_RD];
  assign in_r1  = inst_i[WORD-W_OP-W_RD-1 -: W_RD];
  assign in_imm = inst_i[W_IMM-1:0];

  // Head view and handshake; stall_o depends only on registered level
  assign pc_o     = pc_q[rd_ptr_q];
  assign imm_o    = imm_q[rd_ptr_q];
  assign r0_o     = r0_q[rd_ptr_q];
  assign r1_o     = r1_q[rd_ptr_q];
  assign d_info_o = info_q[rd_ptr_q];
  assign level_o  = level_q;
  assign stall_o  = (level_q == LVL_W'(DEPTH));
  assign hazard   = busy_q[r0_o] | busy_q[r1_o];
  assign v_o      = (level_q != '0) & ~hazard & ~branch_i;
  assign issue    = v_o & ~stall_i;
  assign enq      = v_i & ~stall_o & ~branch_i;
  assign w_reserve_o = issue & d_info_o.wrsv;
  assign opr0_o   = r_opr0_i;
  assign opr1_o   = r_opr1_i;

  // Entry storage written at the tail
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        imm_q[i]  <= '0;
        r0_q[i]   <= '0;
        r1_q[i]   <= '0;
        info_q[i] <= '0;
      end
    end else if (enq) begin
      pc_q[wr_ptr_q]   <= pc_i;
      imm_q[wr_ptr_q]  <= in_imm;
      r0_q[wr_ptr_q]   <= in_r0;
      r1_q[wr_ptr_q]   <= in_r1;
      info_q[wr_ptr_q] <= decode_inst(in_op);
    end
  end

  // Pointers and occupancy; a branch empties the queue in one edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else if (branch_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (enq)   wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (issue) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (enq && !issue)      level_q <= level_q + LVL_W'(1);
      else if (!enq && issue) level_q <= level_q - LVL_W'(1);
    end
  end

  // Scoreboard next state: writeback clears, reservation sets and wins a tie
  always_comb begin
    busy_d = busy_q;
    if (wb_v_i)      busy_d[wb_r_i] = 1'b0;
    if (w_reserve_o) busy_d[r0_o]   = 1'b1;
  end

  // Scoreboard register; survives flushes since writebacks are still in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

endmodule
